// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types and constants for the frame buffer scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    WRITING = 2'b01,
    READY   = 2'b10,
    READING = 2'b11
  } buf_state_t;

  localparam int unsigned MAX_NBUF = 4;
  localparam int unsigned IDX_W    = 2;

  localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0020_0000;

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Writer/reader handshake and status bundle of the frame buffer scheduler.
interface frame_buffer_scheduler_if #(
  parameter int unsigned AW = 32
);
  logic          enable_i;
  logic          wr_start_i;
  logic          wr_done_i;
  logic          wr_valid_o;
  logic [1:0]    wr_idx_o;
  logic [AW-1:0] wr_addr_o;
  logic          rd_req_i;
  logic          rd_valid_o;
  logic [1:0]    rd_idx_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_new_o;
  logic [15:0]   drop_cnt_o;
  logic [15:0]   repeat_cnt_o;
  logic [15:0]   abort_cnt_o;

  modport slave (
    input  enable_i, wr_start_i, wr_done_i, rd_req_i,
    output wr_valid_o, wr_idx_o, wr_addr_o,
    output rd_valid_o, rd_idx_o, rd_addr_o, rd_new_o,
    output drop_cnt_o, repeat_cnt_o, abort_cnt_o
  );

  modport master (
    output enable_i, wr_start_i, wr_done_i, rd_req_i,
    input  wr_valid_o, wr_idx_o, wr_addr_o,
    input  rd_valid_o, rd_idx_o, rd_addr_o, rd_new_o,
    input  drop_cnt_o, repeat_cnt_o, abort_cnt_o
  );
endinterface

// File: rtl/frame_buffer_scheduler_pick.sv
// Lowest-index search for buffers in a given state.
module fb_sched_pick
  import fb_sched_pkg::*;
#(
  parameter int unsigned NBUF = 3,
  parameter buf_state_t  WANT = FREE
) (
  input  buf_state_t [NBUF-1:0] state_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (!found_o && state_i[i] == WANT) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer pool scheduler between one capture writer and one reader.
// Define FRAME_BUFFER_SCHEDULER_STATS_EN to build the drop/repeat/abort counters.
module frame_buffer_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned   NBUF         = 3,
  parameter int unsigned   AW           = 32,
  parameter logic [AW-1:0] BASE_ADDR    = AW'(DEF_BASE_ADDR),
  parameter logic [AW-1:0] FRAME_STRIDE = AW'(DEF_FRAME_STRIDE)
) (
  input logic               clk,
  input logic               rstn,
  frame_buffer_scheduler_if.slave bus
);

  buf_state_t [NBUF-1:0] st_q, st_a, st_b, st_d;
  logic                  wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic                  rd_new_q, rd_new_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

  logic             wing_f, rdy0_f, free_f, rdy1_f, rding_f;
  logic [IDX_W-1:0] wing_i, rdy0_i, free_i, rdy1_i, rding_i;
  logic             steal, ready_b;

  fb_sched_pick #(.NBUF(NBUF), .WANT(WRITING)) u_pick_wr   (.state_i(st_q), .found_o(wing_f),  .idx_o(wing_i));
  fb_sched_pick #(.NBUF(NBUF), .WANT(READY))   u_pick_rdy0 (.state_i(st_q), .found_o(rdy0_f),  .idx_o(rdy0_i));
  fb_sched_pick #(.NBUF(NBUF), .WANT(READING)) u_pick_rd   (.state_i(st_q), .found_o(rding_f), .idx_o(rding_i));
  fb_sched_pick #(.NBUF(NBUF), .WANT(FREE))    u_pick_free (.state_i(st_a), .found_o(free_f),  .idx_o(free_i));
  fb_sched_pick #(.NBUF(NBUF), .WANT(READY))   u_pick_rdy1 (.state_i(st_a), .found_o(rdy1_f),  .idx_o(rdy1_i));

  // Events are resolved as a chain of intermediate vectors (done/abort, then
  // allocation, then read) so the later stages see the earlier stages' result.
  always_comb begin
    st_a = st_q;
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (bus.wr_done_i && wing_f) begin
        if (rdy0_f && IDX_W'(i) == rdy0_i) st_a[i] = FREE;
        if (IDX_W'(i) == wing_i)           st_a[i] = READY;
      end else if (bus.wr_start_i && wing_f && IDX_W'(i) == wing_i) begin
        st_a[i] = FREE;
      end
    end
  end

  assign steal   = bus.wr_start_i && !free_f && rdy1_f;
  assign ready_b = rdy1_f && !steal;

  always_comb begin
    st_b       = st_a;
    wr_valid_d = wr_valid_q;
    wr_idx_d   = wr_idx_q;
    if (bus.wr_done_i && wing_f) wr_valid_d = 1'b0;
    if (bus.wr_start_i) begin
      if (free_f || rdy1_f) begin
        wr_idx_d   = free_f ? free_i : rdy1_i;
        wr_valid_d = 1'b1;
        for (int unsigned i = 0; i < NBUF; i++)
          if (IDX_W'(i) == wr_idx_d) st_b[i] = WRITING;
      end else begin
        wr_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    st_d       = st_b;
    rd_valid_d = rd_valid_q;
    rd_idx_d   = rd_idx_q;
    rd_new_d   = 1'b0;
    if (bus.rd_req_i && ready_b) begin
      for (int unsigned i = 0; i < NBUF; i++) begin
        if (rding_f && IDX_W'(i) == rding_i) st_d[i] = FREE;
        if (IDX_W'(i) == rdy1_i)             st_d[i] = READING;
      end
      rd_idx_d   = rdy1_i;
      rd_valid_d = 1'b1;
      rd_new_d   = 1'b1;
    end
  end

  assign wr_addr_d = BASE_ADDR + AW'(wr_idx_d) * FRAME_STRIDE;
  assign rd_addr_d = BASE_ADDR + AW'(rd_idx_d) * FRAME_STRIDE;

  always_ff @(posedge clk) begin
    if (!rstn || !bus.enable_i) begin
      for (int unsigned i = 0; i < NBUF; i++) st_q[i] <= FREE;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_new_q   <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_addr_q  <= BASE_ADDR;
      rd_addr_q  <= BASE_ADDR;
    end else begin
      st_q       <= st_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      rd_new_q   <= rd_new_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bus.wr_valid_o = wr_valid_q;
  assign bus.wr_idx_o   = wr_idx_q;
  assign bus.wr_addr_o  = wr_addr_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_idx_o   = rd_idx_q;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.rd_new_o   = rd_new_q;

`ifdef FRAME_BUFFER_SCHEDULER_STATS_EN
  logic [15:0] drop_q, repeat_q, abort_q;
  logic        drop_ev, repeat_ev, abort_ev;

  assign drop_ev   = (bus.wr_done_i && wing_f && rdy0_f) || steal;
  assign abort_ev  = bus.wr_start_i && !bus.wr_done_i && wing_f;
  assign repeat_ev = bus.rd_req_i && !ready_b && rd_valid_q;

  always_ff @(posedge clk) begin
    if (!rstn || !bus.enable_i) begin
      drop_q   <= '0;
      repeat_q <= '0;
      abort_q  <= '0;
    end else begin
      if (drop_ev   && drop_q   != '1) drop_q   <= drop_q + 16'd1;
      if (repeat_ev && repeat_q != '1) repeat_q <= repeat_q + 16'd1;
      if (abort_ev  && abort_q  != '1) abort_q  <= abort_q + 16'd1;
    end
  end

  assign bus.drop_cnt_o   = drop_q;
  assign bus.repeat_cnt_o = repeat_q;
  assign bus.abort_cnt_o  = abort_q;
`else
  assign bus.drop_cnt_o   = '0;
  assign bus.repeat_cnt_o = '0;
  assign bus.abort_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench: NBUF=3 and NBUF=2 schedulers driven in lockstep against a role-based model.
module tb_frame_buffer_scheduler;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0020_0000;
`ifdef FRAME_BUFFER_SCHEDULER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  frame_buffer_scheduler_if #(.AW(32)) if3 ();
  frame_buffer_scheduler_if #(.AW(32)) if2 ();

  frame_buffer_scheduler #(.NBUF(3), .AW(32), .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE))
    u_dut3 (.clk(clk), .rstn(rstn), .bus(if3));
  frame_buffer_scheduler #(.NBUF(2), .AW(32), .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE))
    u_dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  // Model: which buffer plays each role (-1 = none), per instance.
  int nbuf [2] = '{3, 2};
  int m_wr [2], m_rdy [2], m_rd [2], m_widx [2], m_ridx [2], m_new [2];
  int m_drop [2], m_rep [2], m_abort [2];

  logic [31:0] got [10];
  logic [31:0] exp_v [10];
  string names [10] = '{"wr_valid", "wr_idx", "wr_addr", "rd_valid", "rd_idx",
                        "rd_addr", "rd_new", "drop_cnt", "repeat_cnt", "abort_cnt"};

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + STRIDE * 32'(idx);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = -1; m_rdy[k] = -1; m_rd[k] = -1;
      m_widx[k] = 0; m_ridx[k] = 0; m_new[k] = 0;
      m_drop[k] = 0; m_rep[k] = 0; m_abort[k] = 0;
    end
  endtask

  task automatic model_step(input bit d, input bit s, input bit r);
    int pick;
    for (int k = 0; k < 2; k++) begin
      m_new[k] = 0;
      if (d && m_wr[k] >= 0) begin
        if (m_rdy[k] >= 0) m_drop[k] = sat(m_drop[k] + 1);
        m_rdy[k] = m_wr[k];
        m_wr[k]  = -1;
      end
      if (s) begin
        if (m_wr[k] >= 0) begin
          m_abort[k] = sat(m_abort[k] + 1);
          m_wr[k]    = -1;
        end
        pick = -1;
        for (int i = nbuf[k] - 1; i >= 0; i--)
          if (i != m_rdy[k] && i != m_rd[k]) pick = i;
        if (pick < 0) begin
          m_drop[k] = sat(m_drop[k] + 1);
          pick      = m_rdy[k];
          m_rdy[k]  = -1;
        end
        m_wr[k]   = pick;
        m_widx[k] = pick;
      end
      if (r) begin
        if (m_rdy[k] >= 0) begin
          m_rd[k]   = m_rdy[k];
          m_ridx[k] = m_rdy[k];
          m_rdy[k]  = -1;
          m_new[k]  = 1;
        end else if (m_rd[k] >= 0) begin
          m_rep[k] = sat(m_rep[k] + 1);
        end
      end
    end
  endtask

  task automatic step(input bit en, input bit d, input bit s, input bit r);
    if3.enable_i = en; if3.wr_done_i = d; if3.wr_start_i = s; if3.rd_req_i = r;
    if2.enable_i = en; if2.wr_done_i = d; if2.wr_start_i = s; if2.rd_req_i = r;
    @(posedge clk);
    if (!rstn || !en) model_reset();
    else model_step(d, s, r);
    #1;
  endtask

  task automatic sample(input int k);
    if (k == 0) begin
      got[0] = 32'(if3.wr_valid_o); got[1] = 32'(if3.wr_idx_o); got[2] = if3.wr_addr_o;
      got[3] = 32'(if3.rd_valid_o); got[4] = 32'(if3.rd_idx_o); got[5] = if3.rd_addr_o;
      got[6] = 32'(if3.rd_new_o);   got[7] = 32'(if3.drop_cnt_o);
      got[8] = 32'(if3.repeat_cnt_o); got[9] = 32'(if3.abort_cnt_o);
    end else begin
      got[0] = 32'(if2.wr_valid_o); got[1] = 32'(if2.wr_idx_o); got[2] = if2.wr_addr_o;
      got[3] = 32'(if2.rd_valid_o); got[4] = 32'(if2.rd_idx_o); got[5] = if2.rd_addr_o;
      got[6] = 32'(if2.rd_new_o);   got[7] = 32'(if2.drop_cnt_o);
      got[8] = 32'(if2.repeat_cnt_o); got[9] = 32'(if2.abort_cnt_o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      sample(k);
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (got[j] !== ((j == 2 || j == 5) ? BASE : 32'd0)) begin
          errors++;
          $display("FAIL reset_%s nbuf=%0d got %0h expected %0h", names[j], nbuf[k], got[j],
                   (j == 2 || j == 5) ? BASE : 32'd0);
        end
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_first_write();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if3.wr_idx_o !== 2'd0) begin errors++; $display("FAIL first_wr_idx got %0d expected 0", if3.wr_idx_o); end
    checks++;
    if (if3.wr_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL first_wr_addr got %0h expected 10000000", if3.wr_addr_o); end
    checks++;
    if (if3.wr_valid_o !== 1'b1) begin errors++; $display("FAIL first_wr_valid got %0b expected 1", if3.wr_valid_o); end
  endtask

  task automatic test_first_read();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if3.rd_idx_o !== 2'd0) begin errors++; $display("FAIL first_rd_idx got %0d expected 0", if3.rd_idx_o); end
    checks++;
    if (if3.rd_new_o !== 1'b1) begin errors++; $display("FAIL first_rd_new got %0b expected 1", if3.rd_new_o); end
    checks++;
    if (if3.rd_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL first_rd_addr got %0h expected 10000000", if3.rd_addr_o); end
    checks++;
    if (if3.rd_valid_o !== 1'b1) begin errors++; $display("FAIL first_rd_valid got %0b expected 1", if3.rd_valid_o); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (if3.rd_new_o !== 1'b0) begin errors++; $display("FAIL rd_new_pulse got %0b expected 0", if3.rd_new_o); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if3.wr_idx_o !== 2'd1) begin errors++; $display("FAIL second_wr_idx got %0d expected 1", if3.wr_idx_o); end
  endtask

  task automatic test_drop();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if3.wr_addr_o !== 32'h1040_0000) begin errors++; $display("FAIL drop_wr_addr got %0h expected 10400000", if3.wr_addr_o); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if3.drop_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL drop_cnt got %0d expected %0d", if3.drop_cnt_o, STATS ? 1 : 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if3.rd_idx_o !== 2'd2) begin errors++; $display("FAIL drop_rd_idx got %0d expected 2", if3.rd_idx_o); end
  endtask

  task automatic test_repeat_abort();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if3.rd_new_o !== 1'b0) begin errors++; $display("FAIL repeat_rd_new got %0b expected 0", if3.rd_new_o); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if3.rd_idx_o !== 2'd2) begin errors++; $display("FAIL repeat_rd_idx got %0d expected 2", if3.rd_idx_o); end
    checks++;
    if (if3.repeat_cnt_o !== (STATS ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL repeat_cnt got %0d expected %0d", if3.repeat_cnt_o, STATS ? 2 : 0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if3.abort_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL abort_cnt got %0d expected %0d", if3.abort_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_done_and_read();
    int wr_before;
    wr_before = m_widx[0];
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (32'(if3.rd_idx_o) !== 32'(wr_before)) begin
      errors++; $display("FAIL simul_rd_idx got %0d expected %0d", if3.rd_idx_o, wr_before);
    end
    checks++;
    if (if3.rd_new_o !== 1'b1) begin errors++; $display("FAIL simul_rd_new got %0b expected 1", if3.rd_new_o); end
    checks++;
    if (if3.drop_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL simul_drop_cnt got %0d expected %0d", if3.drop_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_nbuf2_steal_flush();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if2.wr_idx_o !== 2'd1) begin errors++; $display("FAIL steal_wr_idx got %0d expected 1", if2.wr_idx_o); end
    checks++;
    if (if2.drop_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL steal_drop_cnt got %0d expected %0d", if2.drop_cnt_o, STATS ? 1 : 0);
    end
    checks++;
    if (if2.rd_idx_o !== 2'd0) begin errors++; $display("FAIL steal_rd_idx got %0d expected 0", if2.rd_idx_o); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sample(k);
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (got[j] !== ((j == 2 || j == 5) ? BASE : 32'd0)) begin
          errors++;
          $display("FAIL flush_%s nbuf=%0d got %0h expected %0h", names[j], nbuf[k], got[j],
                   (j == 2 || j == 5) ? BASE : 32'd0);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        sample(k);
        exp_v[0] = 32'(m_wr[k] >= 0);
        exp_v[1] = 32'(m_widx[k]);
        exp_v[2] = addr_of(m_widx[k]);
        exp_v[3] = 32'(m_rd[k] >= 0);
        exp_v[4] = 32'(m_ridx[k]);
        exp_v[5] = addr_of(m_ridx[k]);
        exp_v[6] = 32'(m_new[k]);
        exp_v[7] = STATS ? 32'(m_drop[k])  : 32'd0;
        exp_v[8] = STATS ? 32'(m_rep[k])   : 32'd0;
        exp_v[9] = STATS ? 32'(m_abort[k]) : 32'd0;
        for (int j = 0; j < 10; j++) begin
          checks++;
          if (got[j] !== exp_v[j]) begin
            errors++;
            $display("FAIL random_%s nbuf=%0d cycle=%0d got %0h expected %0h",
                     names[j], nbuf[k], c, got[j], exp_v[j]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_write();
    test_first_read();
    test_drop();
    test_repeat_abort();
    test_done_and_read();
    test_nbuf2_steal_flush();
    test_random(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Schedules a pool of NBUF DDR frame buffers between one capture writer and one display/DMA reader.
- Writer: the video stream-to-memory path, driven by BT.656 capture new-frame and frame-end events.
- Reader: the display or readback master, driven by its own frame requests.
- Hands out buffer index and base address to each side, always giving the reader the newest complete frame, and counts dropped, repeated and aborted frames.

Parameters:
- NBUF, 3, number of frame buffers; legal range 2..4.
- AW, 32, address width.
- BASE_ADDR, 32'h1000_0000, address of buffer 0.
- FRAME_STRIDE, 32'h0020_0000, byte distance between buffers; covers 1280x720 YCbCr 4:2:2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- enable_i  in  1  scheduler enable; low = flush.
- wr_start_i  in  1  pulse: writer starts a new frame.
- wr_done_i  in  1  pulse: writer finished the current frame completely.
- wr_valid_o  out  1  a buffer is allocated to the writer.
- wr_idx_o  out  2  writer buffer index.
- wr_addr_o  out  AW  BASE_ADDR + wr_idx_o*FRAME_STRIDE.
- rd_req_i  in  1  pulse: reader starts a new frame period.
- rd_valid_o  out  1  reader holds a valid frame.
- rd_idx_o  out  2  reader buffer index.
- rd_addr_o  out  AW  BASE_ADDR + rd_idx_o*FRAME_STRIDE.
- rd_new_o  out  1  one-cycle pulse: rd_idx_o changed to a fresh frame.
- drop_cnt_o  out  16  frames completed but never read.
- repeat_cnt_o  out  16  rd_req_i with no new frame available.
- abort_cnt_o  out  16  wr_start_i while previous frame still writing.

Behaviour:
- Buffer state: each buffer is FREE, WRITING, READY or READING.
- Invariants: at most one WRITING, one READY, one READING.
- Reset (rstn=0) or enable_i=0:
  - all buffers FREE.
  - wr_valid_o=0, rd_valid_o=0, rd_new_o=0.
  - wr_idx_o=0, rd_idx_o=0; addresses = BASE_ADDR.
  - all counters 0.
  - Holds while enable_i is low; reset mid-frame discards all state.
- All outputs are registered; each event's effect is visible the cycle after the input pulse.
- Per-cycle processing order: wr_done_i, then wr_start_i, then rd_req_i, all applied in the same cycle with combined next-state.
- wr_done_i with a WRITING buffer:
  - WRITING -> READY.
  - Any previous READY -> FREE, drop_cnt_o+1.
  - wr_valid_o -> 0.
- wr_done_i with no WRITING buffer is ignored.
- wr_start_i:
  - If a buffer is still WRITING: WRITING -> FREE, abort_cnt_o+1.
  - Allocate the lowest-index FREE buffer.
  - If none is FREE (NBUF=2 only), steal the READY buffer and increment drop_cnt_o.
  - The READING buffer is never allocated.
  - Allocated buffer -> WRITING; wr_valid_o=1; wr_idx_o/wr_addr_o update.
- rd_req_i with a READY buffer present:
  - current READING -> FREE.
  - READY -> READING; rd_idx_o updates; rd_valid_o=1; rd_new_o pulses 1 cycle.
- rd_req_i with no READY buffer:
  - Keep the current buffer; if rd_valid_o=1, repeat_cnt_o+1.
  - If rd_valid_o=0, nothing counts.
- Simultaneous wr_done_i + rd_req_i: the reader receives the frame just completed.
- Simultaneous wr_done_i + wr_start_i: the completed frame becomes READY and the new write gets a FREE buffer; no abort.
- Counters saturate at 16'hFFFF.
- Address arithmetic: idx zero-extended to AW, multiplied by FRAME_STRIDE, added to BASE_ADDR, truncated to AW. Computed registered, in the same cycle as the idx update.

Optional Feature:
- Macro: FRAME_BUFFER_SCHEDULER_STATS_EN.
- Defined: drop/repeat/abort counters as specified.
- Undefined: counter logic is absent and drop_cnt_o, repeat_cnt_o and abort_cnt_o are tied to 0; scheduling behaviour is identical.

Decomposition:
- Package fb_sched_pkg:
  - buf_state_t enum (FREE=2'b00, WRITING=2'b01, READY=2'b10, READING=2'b11).
  - MAX_NBUF=4 and IDX_W=2 constants.
  - Default FRAME_STRIDE constant.
- Sub-module fb_sched_pick: combinational lowest-index finder over an NBUF-wide state vector for a requested buf_state_t; returns found flag and index. Instantiated for FREE, READY, READING lookups.

Test Plan:
- NBUF=3, reset then wr_start -> wr_idx_o=0, wr_addr_o=32'h1000_0000, wr_valid_o=1 next cycle.
- Frame 0 start/done, then rd_req -> rd_idx_o=0, rd_new_o one pulse, rd_addr_o=32'h1000_0000; next wr_start -> wr_idx_o=1.
- Two complete frames (idx 1, then 2) with no rd_req while reader holds 0 -> buffer 1 FREE, drop_cnt_o=1; rd_req -> rd_idx_o=2.
- rd_req twice with no new frame -> rd_idx_o unchanged, rd_new_o=0, repeat_cnt_o=2; wr_start twice without done -> abort_cnt_o=1.
- wr_done_i and rd_req_i in the same cycle -> rd_idx_o equals the just-finished wr_idx_o, drop_cnt_o unchanged.
- NBUF=2, reader on 0, buffer 1 READY, wr_start -> wr_idx_o=1, drop_cnt_o=1; then enable_i=0 mid-frame -> all valids 0, counters 0 next cycle.
